uart_rx_frame_ctrl: RTL and testbench

- UART receive front end: oversamples RX_IN, majority-votes each bit, deserializes LSB-first data and checks parity.
- Sequences the frame and drives the stop-bit checker: supplies the voted bit and a one-cycle check enable, and takes back the combinational stop-error result.
- Delivers the parallel byte with a one-cycle data_valid strobe when the frame is error-free.

---
 rtl/uart_rx_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: oversampled majority-vote sampling,
// LSB-first deserialization, parity check and stop-checker sequencing.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK_stop,
  input  logic                  RST_stop,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  stp_err_chk,
  output logic                  stp_chk_en,
  output logic                  sample_bit_par_chk,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [PRESCALE_W-1:0] pscl_q, pscl_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  glitch_q, glitch_d;

  logic [PRESCALE_W-1:0] half;
  logic                  last_edge;
  logic                  sample_done;
  logic                  exp_par;

  assign half        = pscl_q >> 1;
  assign last_edge   = (edge_q == pscl_q - ONE);
  assign sample_done = (edge_q == half + TWO);
  assign exp_par     = (^shift_q) ^ PAR_TYP;

  always_ff @(posedge CLK_stop or negedge RST_stop) begin
    if (!RST_stop) begin
      state_q    <= S_IDLE;
      pscl_q     <= '0;
      edge_q     <= '0;
      bit_q      <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      smp_q      <= 1'b1;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pscl_q     <= pscl_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      glitch_q   <= glitch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pscl_d     = pscl_q;
    edge_d     = edge_q + ONE;
    bit_d      = bit_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    pdata_d    = pdata_q;
    dv_d       = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    glitch_d   = 1'b0;
    stp_chk_en = 1'b0;

    // three samples around mid-bit, voted into smp_q
    if (state_q != S_IDLE) begin
      if (edge_q == half - ONE) s0_d = RX_IN;
      if (edge_q == half)       s1_d = RX_IN;
      if (edge_q == half + ONE) begin
        smp_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
      end
    end

    if (last_edge) edge_d = '0;

    unique case (state_q)
      S_IDLE: begin
        edge_d = '0;
        if (!RX_IN) begin
          state_d = S_START;
          pscl_d  = Prescale;
        end
      end
      S_START: begin
        if (sample_done && smp_q) begin
          glitch_d = 1'b1;
          state_d  = S_IDLE;
          edge_d   = '0;
        end else if (last_edge) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (sample_done) begin
          shift_d = {smp_q, shift_q[DATA_WIDTH-1:1]};
        end
        if (last_edge) begin
          if (bit_q == LAST_BIT) begin
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (sample_done) par_flag_d = (smp_q != exp_par);
        if (last_edge) state_d = S_STOP;
      end
      S_STOP: begin
        if (sample_done) begin
          stp_chk_en = 1'b1;
          stp_flag_d = stp_err_chk;
        end
        if (last_edge) begin
          par_err_d = par_flag_q;
          stp_err_d = stp_flag_q;
          if (!par_flag_q && !stp_flag_q) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
          // a low line here is the next frame's start bit
          if (!RX_IN) begin
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = '0;
      end
    endcase
  end

  assign sample_bit_par_chk = smp_q;
  assign P_DATA             = pdata_q;
  assign data_valid         = dv_q;
  assign par_err            = par_err_q;
  assign stp_err            = stp_err_q;
  assign strt_glitch        = glitch_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frame table plus
// start-glitch, back-to-back, sample-glitch and mid-frame reset cases.
module tb_uart_rx_frame_ctrl;

  logic       CLK_stop = 1'b0;
  logic       RST_stop = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       stp_err_chk;
  logic       stp_chk_en;
  logic       sample_bit_par_chk;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;
  logic       busy;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK_stop(CLK_stop),
    .RST_stop(RST_stop),
    .RX_IN(RX_IN),
    .Prescale(Prescale),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .stp_err_chk(stp_err_chk),
    .stp_chk_en(stp_chk_en),
    .sample_bit_par_chk(sample_bit_par_chk),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .par_err(par_err),
    .stp_err(stp_err),
    .strt_glitch(strt_glitch),
    .busy(busy)
  );

  always #5 CLK_stop = ~CLK_stop;

  // stop checker model: a voted 0 during the check is a bad stop bit
  assign stp_err_chk = stp_chk_en & ~sample_bit_par_chk;

  int cyc = 0;
  always @(posedge CLK_stop) cyc <= cyc + 1;

  int         stp_n = 0;
  int         stp_cyc = 0;
  int         gl_n = 0;
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];

  always @(negedge CLK_stop) begin
    if (data_valid) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(P_DATA);
    end
    if (stp_chk_en) begin
      stp_n   <= stp_n + 1;
      stp_cyc <= cyc;
    end
    if (strt_glitch) gl_n <= gl_n + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK_stop);
      #1;
      RX_IN = 1'b1;
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] d,
                            input bit pe, input logic pb,
                            input logic sb, input int gbit,
                            output int n0);
    logic [11:0] bits;
    int          nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) begin
      bits[9] = pb;
      bits[10] = sb;
      nb = 11;
    end else begin
      bits[9] = sb;
      nb = 10;
    end
    n0 = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        @(posedge CLK_stop);
        #1;
        RX_IN = bits[b];
        if (gbit >= 0 && b == gbit + 1 && c == p / 2 + 1)
          RX_IN = ~bits[b];
        if (b == 0 && c == 0) n0 = cyc;
      end
    end
  endtask

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    bit         ev;
    logic [7:0] ed;
    logic       epe;
    logic       ese;
  } vec_t;

  vec_t tv[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, b0, s0, g0, f, sz;
    string nm;

    tv[0] = '{8,  0, 0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{16, 1, 0, 8'h3C, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
    tv[2] = '{16, 1, 0, 8'h3C, 1'b1, 1'b1, 0, 8'h3C, 1'b1, 1'b0};
    tv[3] = '{8,  0, 0, 8'hC3, 1'b0, 1'b0, 0, 8'h3C, 1'b0, 1'b1};
    tv[4] = '{16, 1, 1, 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 1'b0};
    tv[5] = '{32, 0, 0, 8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b0, 1'b0};

    repeat (3) @(posedge CLK_stop);
    #1;
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_par_err", 32'(par_err), 32'h0);
    chk("rst_stp_err", 32'(stp_err), 32'h0);
    chk("rst_glitch", 32'(strt_glitch), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_stp_chk_en", 32'(stp_chk_en), 32'h0);
    chk("rst_sample", 32'(sample_bit_par_chk), 32'h1);
    RST_stop = 1'b1;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      Prescale = tv[i].p[5:0];
      PAR_EN = tv[i].pe;
      PAR_TYP = tv[i].pt;
      f = tv[i].pe ? 11 : 10;
      sz = dv_cyc.size();
      s0 = stp_n;
      send_frame(tv[i].p, tv[i].d, tv[i].pe, tv[i].pb, tv[i].sb, -1, n0);
      idle(2 * tv[i].p + 5);
      nm = $sformatf("v%0d", i);
      chk({nm, "_dv_count"}, 32'(dv_cyc.size() - sz), 32'(tv[i].ev));
      if (tv[i].ev && dv_cyc.size() > sz)
        chk({nm, "_dv_cycle"}, 32'(dv_cyc[sz] - n0), 32'(1 + f * tv[i].p));
      chk({nm, "_pdata"}, 32'(P_DATA), 32'(tv[i].ed));
      chk({nm, "_par_err"}, 32'(par_err), 32'(tv[i].epe));
      chk({nm, "_stp_err"}, 32'(stp_err), 32'(tv[i].ese));
      chk({nm, "_busy"}, 32'(busy), 32'h0);
      chk({nm, "_stp_chk_count"}, 32'(stp_n - s0), 32'h1);
      chk({nm, "_stp_chk_cycle"}, 32'(stp_cyc - n0),
          32'(1 + (f - 1) * tv[i].p + tv[i].p / 2 + 2));
    end

    Prescale = 6'd8;
    PAR_EN = 1'b0;
    g0 = gl_n;
    s0 = stp_n;
    sz = dv_cyc.size();
    @(posedge CLK_stop);
    #1;
    RX_IN = 1'b0;
    @(posedge CLK_stop);
    #1;
    RX_IN = 1'b0;
    idle(20);
    chk("glitch_count", 32'(gl_n - g0), 32'h1);
    chk("glitch_busy", 32'(busy), 32'h0);
    chk("glitch_stp_chk", 32'(stp_n - s0), 32'h0);
    chk("glitch_dv", 32'(dv_cyc.size() - sz), 32'h0);

    Prescale = 6'd32;
    sz = dv_cyc.size();
    send_frame(32, 8'h01, 0, 1'b0, 1'b1, -1, n0);
    send_frame(32, 8'hFE, 0, 1'b0, 1'b1, -1, n1);
    idle(80);
    chk("b2b_count", 32'(dv_cyc.size() - sz), 32'h2);
    if (dv_cyc.size() >= sz + 2) begin
      chk("b2b_first_cycle", 32'(dv_cyc[sz] - n0), 32'd321);
      chk("b2b_spacing", 32'(dv_cyc[sz+1] - dv_cyc[sz]), 32'd320);
      chk("b2b_data0", 32'(dv_dat[sz]), 32'h01);
      chk("b2b_data1", 32'(dv_dat[sz+1]), 32'hFE);
    end

    Prescale = 6'd16;
    sz = dv_cyc.size();
    send_frame(16, 8'h96, 0, 1'b0, 1'b1, 2, n0);
    idle(40);
    chk("midglitch_count", 32'(dv_cyc.size() - sz), 32'h1);
    chk("midglitch_pdata", 32'(P_DATA), 32'h96);

    Prescale = 6'd8;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK_stop);
      #1;
      RX_IN = 1'b0;
    end
    for (int c = 0; c < 24; c++) begin
      @(posedge CLK_stop);
      #1;
      RX_IN = c[3];
    end
    chk("pre_rst_busy", 32'(busy), 32'h1);
    RST_stop = 1'b0;
    RX_IN = 1'b1;
    #1;
    chk("arst_pdata", 32'(P_DATA), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_sample", 32'(sample_bit_par_chk), 32'h1);
    chk("arst_dv", 32'(data_valid), 32'h0);
    chk("arst_errs", 32'({par_err, stp_err, strt_glitch}), 32'h0);
    repeat (2) @(posedge CLK_stop);
    #1;
    RST_stop = 1'b1;
    sz = dv_cyc.size();
    idle(150);
    chk("post_rst_dv", 32'(dv_cyc.size() - sz), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
